// File: rtl/csr_exec.sv
// csr_exec: executes one Zicsr instruction at a time against an external CSR file.
// Ports: clk, rst (async, active-low); in_* decoded instruction (valid/ready);
//   kill aborts the in-flight instruction; req_* request to the CSR file
//   (valid/ready); resp_* CSR-file response; out_* result (valid/ready).
module csr_exec #(
  parameter int XLEN           = 32,
  parameter int FLUSH_ON_WRITE = 1,
  parameter int RO_CHECK       = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [4:0]      in_rs1,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [11:0]     in_csr,
  input  logic [4:0]      in_rd,
  input  logic            kill,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [11:0]     req_addr,
  output logic [XLEN-1:0] req_data,
  output logic [1:0]      req_op,
  output logic            req_wen,
  input  logic            resp_valid,
  input  logic            resp_exists,
  input  logic [XLEN-1:0] resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_rd_val,
  output logic            out_ex,
  output logic [3:0]      out_ex_cause,
  output logic            out_flush
);

  localparam logic       FLUSH_EN  = (FLUSH_ON_WRITE != 0);
  localparam logic       RO_EN     = (RO_CHECK != 0);
  localparam logic [3:0] CAUSE_ILL = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [1:0]      op_in;
  logic            wen_in;
  logic            ro_hit;
  logic            pre_ex;
  logic            accept;
  logic            take;
  logic            pre_load;
  logic            resp_load;
  logic [XLEN-1:0] operand;
  logic [4:0]      rd_q;

  assign op_in  = in_funct3[1:0];
  // RS/RC with x0 or zimm 0 are pure reads; the index decides for both forms.
  assign wen_in = (op_in == 2'b01) || (in_rs1 != 5'd0);
  assign ro_hit = RO_EN && wen_in && (in_csr[11:10] == 2'b11);
  assign pre_ex = (op_in == 2'b00) || ro_hit;

  assign operand = in_funct3[2] ? {{(XLEN-5){1'b0}}, in_rs1}
                                : in_rs1_val;

  assign in_ready  = (state == S_IDLE);
  assign req_valid = (state == S_REQ);
  assign out_valid = (state == S_DONE);

  assign accept    = in_valid && in_ready;
  // An instruction killed in the cycle it is offered is simply dropped.
  assign take      = accept && !kill;
  assign pre_load  = take && pre_ex;
  assign resp_load = (state == S_RESP) && resp_valid && !kill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (take) begin
          state_nx = pre_ex ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        // A kill racing the handshake still owes the CSR file a response slot.
        if (kill) begin
          state_nx = req_ready ? S_DRAIN : S_IDLE;
        end else if (req_ready) begin
          state_nx = S_RESP;
        end
      end
      S_RESP: begin
        if (kill) begin
          state_nx = resp_valid ? S_IDLE : S_DRAIN;
        end else if (resp_valid) begin
          state_nx = S_DONE;
        end
      end
      S_DRAIN: begin
        if (resp_valid) begin
          state_nx = S_IDLE;
        end
      end
      S_DONE: begin
        if (kill || out_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr <= '0;
      req_data <= '0;
      req_op   <= '0;
      req_wen  <= 1'b0;
      rd_q     <= '0;
    end else if (take) begin
      req_addr <= in_csr;
      req_data <= operand;
      req_op   <= op_in;
      req_wen  <= wen_in;
      rd_q     <= in_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_rd       <= '0;
      out_rd_val   <= '0;
      out_ex       <= 1'b0;
      out_ex_cause <= '0;
      out_flush    <= 1'b0;
    end else if (pre_load) begin
      out_rd       <= '0;
      out_rd_val   <= '0;
      out_ex       <= 1'b1;
      out_ex_cause <= CAUSE_ILL;
      out_flush    <= 1'b0;
    end else if (resp_load) begin
      if (resp_exists) begin
        out_rd       <= rd_q;
        out_rd_val   <= resp_data;
        out_ex       <= 1'b0;
        out_ex_cause <= '0;
        out_flush    <= FLUSH_EN && req_wen;
      end else begin
        out_rd       <= '0;
        out_rd_val   <= '0;
        out_ex       <= 1'b1;
        out_ex_cause <= CAUSE_ILL;
        out_flush    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csr_exec.sv
// tb_csr_exec: directed table plus randomized transactions for csr_exec,
// with hand-written kill and reset sequences.
module tb_csr_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1, in_rd;
  logic [31:0] in_rs1_val;
  logic [11:0] in_csr;
  logic        kill;
  logic        req_valid, req_ready, req_wen;
  logic [11:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_op;
  logic        resp_valid, resp_exists;
  logic [31:0] resp_data;
  logic        out_valid, out_ready, out_ex, out_flush;
  logic [4:0]  out_rd;
  logic [31:0] out_rd_val;
  logic [3:0]  out_ex_cause;

  csr_exec dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_rs1(in_rs1),
    .in_rs1_val(in_rs1_val), .in_csr(in_csr),
    .in_rd(in_rd), .kill(kill),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .req_op(req_op), .req_wen(req_wen),
    .resp_valid(resp_valid), .resp_exists(resp_exists),
    .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rd_val(out_rd_val),
    .out_ex(out_ex), .out_ex_cause(out_ex_cause),
    .out_flush(out_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [31:0] rs1_val;
    logic [11:0] csr;
    logic [4:0]  rd;
    logic        ex_ok;
    logic [31:0] rdata;
    int          rdly;
    int          pdly;
    int          odly;
    logic        e_req;
    logic [1:0]  e_op;
    logic        e_wen;
    logic [31:0] e_data;
    logic        e_ex;
    logic [4:0]  e_rd;
    logic [31:0] e_val;
    logic        e_flush;
    int          e_lat;
  } vec_t;

  typedef struct {
    logic        saw_req;
    logic [1:0]  op;
    logic        wen;
    logic [31:0] data;
    logic [11:0] addr;
    logic        saw_out;
    logic        ex;
    logic [3:0]  cause;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        flush;
    int          lat;
    logic        unstable;
    logic        timeout;
    logic        rdy_after;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: the instruction's outcome from the architectural rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic [1:0] op = v.f3[1:0];
    logic wen = (op == 2'd1) || (v.rs1 != 0);
    logic bad = (op == 2'd0) || (wen && v.csr[11:10] == 2'b11);
    r.e_req   = !bad;
    r.e_op    = op;
    r.e_wen   = wen;
    r.e_data  = v.f3[2] ? 32'(v.rs1) : v.rs1_val;
    r.e_ex    = bad || !v.ex_ok;
    r.e_rd    = r.e_ex ? 5'd0 : v.rd;
    r.e_val   = r.e_ex ? 32'd0 : v.rdata;
    r.e_flush = wen && !r.e_ex;
    r.e_lat   = bad ? 1 : 3 + v.rdly + v.pdly;
    return r;
  endfunction

  task automatic set_in(input vec_t v);
    in_funct3   = v.f3;
    in_rs1      = v.rs1;
    in_rs1_val  = v.rs1_val;
    in_csr      = v.csr;
    in_rd       = v.rd;
    resp_exists = v.ex_ok;
    resp_data   = v.rdata;
  endtask

  task automatic do_txn(input vec_t v, output obs_t o);
    int lat = 0, rcnt = 0, pcnt = 0, ocnt = 0;
    bit req_fired = 0, resp_pend = 0, out_fired = 0, done = 0;
    o = '{default: 0};
    @(negedge clk);
    if (!in_ready) o.unstable = 1;
    in_valid = 1'b1;
    set_in(v);
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      lat++;
      in_valid   = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      out_ready  = 1'b0;
      if (out_fired) begin
        o.rdy_after = in_ready;
        if (out_valid) o.unstable = 1;
        done = 1;
      end else begin
        if (in_ready) o.unstable = 1;
        if (req_fired) begin
          req_fired = 0;
          resp_pend = 1;
          pcnt = 0;
        end
        if (resp_pend) begin
          if (pcnt == v.pdly) begin
            resp_valid = 1'b1;
            resp_pend = 0;
          end else pcnt++;
        end
        if (req_valid) begin
          if (!o.saw_req) begin
            o.saw_req = 1;
            o.op = req_op;
            o.wen = req_wen;
            o.data = req_data;
            o.addr = req_addr;
          end else if (o.op != req_op || o.wen != req_wen ||
                       o.data != req_data || o.addr != req_addr)
            o.unstable = 1;
          if (rcnt == v.rdly) begin
            req_ready = 1'b1;
            req_fired = 1;
          end else rcnt++;
        end
        if (out_valid) begin
          if (!o.saw_out) begin
            o.saw_out = 1;
            o.lat = lat;
            o.ex = out_ex;
            o.cause = out_ex_cause;
            o.rd = out_rd;
            o.val = out_rd_val;
            o.flush = out_flush;
          end else if (o.ex != out_ex || o.cause != out_ex_cause ||
                       o.rd != out_rd || o.val != out_rd_val ||
                       o.flush != out_flush)
            o.unstable = 1;
          if (ocnt == v.odly) begin
            out_ready = 1'b1;
            out_fired = 1;
          end else ocnt++;
        end
      end
    end
    if (!done) o.timeout = 1;
  endtask

  task automatic check_txn(input string t, input vec_t v, input obs_t o);
    chk({t, ".timeout"}, o.timeout, 0);
    chk({t, ".req_seen"}, o.saw_req, v.e_req);
    if (v.e_req) begin
      chk({t, ".req_op"}, o.op, v.e_op);
      chk({t, ".req_wen"}, o.wen, v.e_wen);
      chk({t, ".req_data"}, o.data, v.e_data);
      chk({t, ".req_addr"}, o.addr, v.csr);
    end
    chk({t, ".out_ex"}, o.ex, v.e_ex);
    if (v.e_ex) chk({t, ".cause"}, o.cause, 4'd2);
    chk({t, ".out_rd"}, o.rd, v.e_rd);
    chk({t, ".out_rd_val"}, o.val, v.e_val);
    chk({t, ".out_flush"}, o.flush, v.e_flush);
    chk({t, ".latency"}, o.lat, v.e_lat);
    chk({t, ".stable"}, o.unstable, 0);
    chk({t, ".in_ready_after"}, o.rdy_after, 1);
  endtask

  vec_t tbl[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    obs_t o;
    // f3 rs1 rs1_val csr rd ex_ok rdata rdly pdly odly |
    // e_req e_op e_wen e_data e_ex e_rd e_val e_flush e_lat
    tbl[0] = '{3'b001, 5'd1, 32'h1234_5678, 12'h300, 5'd5, 1'b1, 32'hA5,
               0, 0, 0, 1'b1, 2'd1, 1'b1, 32'h1234_5678, 1'b0, 5'd5,
               32'hA5, 1'b1, 3};
    tbl[1] = '{3'b010, 5'd0, 32'h0000_DEAD, 12'hC00, 5'd7, 1'b1, 32'h77,
               0, 0, 0, 1'b1, 2'd2, 1'b0, 32'h0000_DEAD, 1'b0, 5'd7,
               32'h77, 1'b0, 3};
    tbl[2] = '{3'b101, 5'd5, 32'h0, 12'hC00, 5'd3, 1'b1, 32'h9,
               0, 0, 0, 1'b0, 2'd1, 1'b1, 32'h5, 1'b1, 5'd0,
               32'h0, 1'b0, 1};
    tbl[3] = '{3'b100, 5'd3, 32'h1, 12'h300, 5'd4, 1'b1, 32'h9,
               0, 0, 0, 1'b0, 2'd0, 1'b1, 32'h3, 1'b1, 5'd0,
               32'h0, 1'b0, 1};
    tbl[4] = '{3'b011, 5'd2, 32'hF0, 12'h7FF, 5'd9, 1'b0, 32'h55,
               0, 0, 0, 1'b1, 2'd3, 1'b1, 32'hF0, 1'b1, 5'd0,
               32'h0, 1'b0, 3};
    tbl[5] = '{3'b110, 5'd31, 32'hFFFF_FFFF, 12'h341, 5'd1, 1'b1,
               32'h1000, 4, 0, 3, 1'b1, 2'd2, 1'b1, 32'h1F, 1'b0, 5'd1,
               32'h1000, 1'b1, 7};
    tbl[6] = '{3'b111, 5'd0, 32'h8, 12'hC01, 5'd2, 1'b1, 32'h42,
               0, 2, 0, 1'b1, 2'd3, 1'b0, 32'h0, 1'b0, 5'd2,
               32'h42, 1'b0, 5};
    tbl[7] = '{3'b001, 5'd0, 32'h0, 12'hF11, 5'd6, 1'b1, 32'h1,
               0, 0, 1, 1'b0, 2'd1, 1'b1, 32'h0, 1'b1, 5'd0,
               32'h0, 1'b0, 1};

    rst = 1'b0;
    in_valid = 0; kill = 0; req_ready = 0; resp_valid = 0; out_ready = 0;
    set_in(tbl[0]);
    #2;
    chk("reset.in_ready", in_ready, 1);
    chk("reset.req_valid", req_valid, 0);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.out_ex", out_ex, 0);
    chk("reset.out_flush", out_flush, 0);
    chk("reset.out_rd", out_rd, 0);
    chk("reset.cause", out_ex_cause, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_txn(tbl[i], o);
      check_txn($sformatf("dir%0d", i), tbl[i], o);
    end

    for (int i = 0; i < 40; i++) begin
      v = '{default: 0};
      v.f3      = 3'($urandom_range(0, 7));
      v.rs1     = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      v.rs1_val = $urandom;
      v.csr     = 12'($urandom);
      v.rd      = 5'($urandom);
      v.ex_ok   = ($urandom_range(0, 4) != 0);
      v.rdata   = $urandom;
      v.rdly    = $urandom_range(0, 2);
      v.pdly    = $urandom_range(0, 2);
      v.odly    = $urandom_range(0, 2);
      v = model(v);
      do_txn(v, o);
      check_txn($sformatf("rnd%0d", i), v, o);
    end

    // kill while the result is waiting: dropped even with out_ready high
    @(negedge clk);
    set_in(tbl[3]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("kdone.out_valid", out_valid, 1);
    kill = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    out_ready = 1'b0;
    chk("kdone.dropped", out_valid, 0);
    chk("kdone.in_ready", in_ready, 1);

    // kill while the request is pending
    set_in(tbl[0]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("kreq.req_valid", req_valid, 1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kreq.req_gone", req_valid, 0);
    chk("kreq.in_ready", in_ready, 1);
    chk("kreq.no_out", out_valid, 0);

    // kill while waiting for the response; response arrives 2 cycles later
    set_in(tbl[0]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    kill = 1'b1;
    chk("kresp.busy", in_ready, 0);
    @(negedge clk);
    kill = 1'b0;
    chk("kresp.drain_busy", in_ready, 0);
    chk("kresp.no_out1", out_valid, 0);
    @(negedge clk);
    resp_valid = 1'b1;
    chk("kresp.drain_wait", in_ready, 0);
    @(negedge clk);
    resp_valid = 1'b0;
    chk("kresp.in_ready", in_ready, 1);
    chk("kresp.no_out2", out_valid, 0);
    @(negedge clk);
    chk("kresp.no_out3", out_valid, 0);
    chk("kresp.no_req", req_valid, 0);

    // reset in the middle of a transaction; out_ex is still 1 from kdone
    set_in(tbl[0]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.req_valid", req_valid, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_ex", out_ex, 0);
    chk("rst.out_flush", out_flush, 0);
    chk("rst.cause", out_ex_cause, 0);
    chk("rst.out_rd", out_rd, 0);
    @(negedge clk);
    rst = 1'b1;
    do_txn(tbl[0], o);
    check_txn("post_rst", tbl[0], o);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_exec.md
CSR_EXEC -- requirements
Module: csr_exec

Interface
REQ-001 Parameter XLEN, default 32, datapath width of register and CSR values.
REQ-002 Parameter FLUSH_ON_WRITE, default 1, nonzero = every CSR write that commits asserts out_flush.
REQ-003 Parameter RO_CHECK, default 1, nonzero = a write to a CSR with addr[11:10]==2'b11 raises an exception.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  decoded CSR instruction offered.
REQ-007 in_ready  out  1  instruction accepted when in_valid && in_ready.
REQ-008 in_funct3  in  3  bit2 = immediate form, bits[1:0] = op (01 RW, 10 RS, 11 RC, 00 illegal).
REQ-009 in_rs1  in  5  rs1 index, also zimm.
REQ-010 in_rs1_val  in  XLEN  rs1 register value.
REQ-011 in_csr  in  12  CSR address.
REQ-012 in_rd  in  5  destination index.
REQ-013 kill  in  1  abort the in-flight instruction (pipeline flush from elsewhere).
REQ-014 req_valid / req_ready  out / in  1 / 1  CSR-file request handshake.
REQ-015 req_addr  out  12; req_data  out  XLEN; req_op  out  2; req_wen  out  1  registered request fields.
REQ-016 resp_valid  in  1; resp_exists  in  1; resp_data  in  XLEN  CSR-file response, earliest one cycle after request accept.
REQ-017 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-018 out_rd  out  5; out_rd_val  out  XLEN; out_ex  out  1; out_ex_cause  out  4; out_flush  out  1  registered result fields.

Function
REQ-019 FSM states IDLE, REQ, RESP, DONE; in_ready SHALL be 1 only in IDLE.
REQ-020 On accept, operand = immediate form ? zero-extended in_rs1 : in_rs1_val; all inputs captured into registers.
REQ-021 Write-enable = (op==RW) || (in_rs1!=0), computed on rs1 index for both forms (RS/RC with x0 or zimm 0 do not write).
REQ-022 Pre-check on accept: op==00 or (RO_CHECK && wen && csr[11:10]==2'b11) -> go directly to DONE with out_ex=1, cause 4'd2, no CSR-file request issued.
REQ-023 Otherwise IDLE -> REQ; req_valid=1 in REQ with stable fields until req_ready; REQ -> RESP on req_ready.
REQ-024 RESP waits any number of cycles for resp_valid; on resp_valid -> DONE, out_rd_val=resp_data.
REQ-025 resp_exists==0 -> out_ex=1, cause 4'd2, out_rd_val=0; CSR file guarantees no side effect for nonexistent CSR.
REQ-026 out_flush = FLUSH_ON_WRITE && wen && !out_ex, registered in DONE.
REQ-027 DONE: out_valid=1, fields stable until out_ready; out_valid && out_ready -> IDLE; next instruction accepted no earlier than the following cycle.
REQ-028 out_rd SHALL be forced to 0 when out_ex=1.
REQ-029 kill in IDLE or REQ: return to IDLE next cycle, no request issued or withdrawn, no result.
REQ-030 kill in RESP: enter a drain sub-state, consume the pending resp_valid, discard it, then IDLE; no result emitted.
REQ-031 kill in DONE: drop result, IDLE next cycle; kill has priority over simultaneous out_ready or resp_valid.
REQ-032 Minimum latency accept-to-out_valid: 3 cycles with req_ready and resp_valid both immediate; 1 cycle on pre-check exception.

Reset
REQ-033 rst low asynchronously forces IDLE; req_valid, out_valid, out_ex, out_flush = 0; out_ex_cause, out_rd = 0; data registers are don't-care.
REQ-034 rst mid-transaction abandons it; the CSR file is reset by the same rst.

Verification
REQ-035 CSRRW rs1_val=0x1234_5678 to 0x300, resp data 0xA5 -> req_op=01 req_wen=1 req_data=0x12345678; out_rd_val=0xA5, out_flush=1, latency 3.
REQ-036 CSRRS rs1=x0 to 0xC00 -> req_wen=0, no exception, out_flush=0; CSRRWI zimm=5 to 0xC00 -> out_ex=1 cause 2, no req_valid ever.
REQ-037 funct3=3'b100 -> out_ex=1 cause 2 after 1 cycle; resp_exists=0 on 0x7FF -> out_ex=1, out_rd=0.
REQ-038 req_ready held low 4 cycles, out_ready low 3 cycles -> req fields and out fields stable throughout, in_ready=0.
REQ-039 kill asserted in RESP, resp_valid 2 cycles later -> no out_valid, in_ready=1 one cycle after drain.
REQ-040 rst pulled low in RESP -> all outputs per REQ-033 immediately, clean CSRRW afterward completes normally.
